// File: rtl/analog_model_pkg.sv
// Shared constants for the analog_model SPI A/D converter model.
// Optional build macro: ANALOG_NOISE_EN adds the LFSR noise helper.
package analog_model_pkg;

    localparam int unsigned FRAME_BITS = 16;
    localparam int unsigned DATA_BITS  = 12;
    localparam int unsigned CNT_W      = 5;
    localparam int unsigned CH_W       = 3;
    localparam int unsigned CH_LSB     = 11;
    localparam int unsigned LFSR_W     = 16;

    localparam logic [CH_W-1:0] CH_BATT   = 3'd0;
    localparam logic [CH_W-1:0] CH_CURR   = 3'd1;
    localparam logic [CH_W-1:0] CH_BRAKE  = 3'd3;
    localparam logic [CH_W-1:0] CH_TORQUE = 3'd4;

    localparam logic [LFSR_W-1:0] LFSR_SEED = 16'hACE1;

`ifdef ANALOG_NOISE_EN
    // Fibonacci LFSR step, taps 16,14,13,11
    function automatic logic [LFSR_W-1:0] lfsr_next(input logic [LFSR_W-1:0] s);
        logic fb;
        fb = s[15] ^ s[13] ^ s[12] ^ s[10];
        return {s[LFSR_W-2:0], fb};
    endfunction
`endif

endpackage

// File: rtl/analog_model_spi_slave_shift.sv
// SPI slave front end: input synchronizers, edge detection and rx/tx shifters.
module spi_slave_shift
    import analog_model_pkg::*;
#(
    parameter int unsigned SYNC_STAGES = 2
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  ss_n,
    input  logic                  sclk,
    input  logic                  mosi,
    input  logic [FRAME_BITS-1:0] load_word,
    output logic                  miso,
    output logic [FRAME_BITS-1:0] rx_word,
    output logic [CNT_W-1:0]      edge_cnt,
    output logic                  ss_rise_c
);

    localparam logic [CNT_W-1:0] CNT_MAX = '1;

    logic [SYNC_STAGES-1:0] ss_sync_q,   ss_sync_d;
    logic [SYNC_STAGES-1:0] sclk_sync_q, sclk_sync_d;
    logic [SYNC_STAGES-1:0] mosi_sync_q, mosi_sync_d;
    logic                   ss_prev_q,   ss_prev_d;
    logic                   sclk_prev_q, sclk_prev_d;
    logic [FRAME_BITS-1:0]  rx_q, rx_d;
    logic [FRAME_BITS-1:0]  tx_q, tx_d;
    logic [CNT_W-1:0]       cnt_q, cnt_d;
    logic                   miso_q, miso_d;

    logic ss_s, sclk_s, mosi_s;
    logic sclk_rise, sclk_fall, ss_fall;

    // Synchronizer shifting, edge detection and shift-register next state
    always_comb begin
        ss_sync_d   = {ss_sync_q[SYNC_STAGES-2:0], ss_n};
        sclk_sync_d = {sclk_sync_q[SYNC_STAGES-2:0], sclk};
        mosi_sync_d = {mosi_sync_q[SYNC_STAGES-2:0], mosi};

        ss_s   = ss_sync_q[SYNC_STAGES-1];
        sclk_s = sclk_sync_q[SYNC_STAGES-1];
        mosi_s = mosi_sync_q[SYNC_STAGES-1];

        ss_prev_d   = ss_s;
        sclk_prev_d = sclk_s;

        sclk_rise = sclk_s & ~sclk_prev_q;
        sclk_fall = ~sclk_s & sclk_prev_q;
        ss_fall   = ~ss_s & ss_prev_q;
        ss_rise_c = ss_s & ~ss_prev_q;

        rx_d  = rx_q;
        tx_d  = tx_q;
        cnt_d = cnt_q;

        if (ss_fall) begin
            tx_d  = load_word;
            cnt_d = '0;
        end else if (!ss_s) begin
            if (sclk_rise) begin
                rx_d = {rx_q[FRAME_BITS-2:0], mosi_s};
                if (cnt_q != CNT_MAX) begin
                    cnt_d = cnt_q + CNT_W'(1);
                end
            end
            // The leading SCLK fall precedes any sample, so the MSB is held until the first rise
            if (sclk_fall && cnt_q != '0) begin
                tx_d = {tx_q[FRAME_BITS-2:0], 1'b0};
            end
        end

        miso_d = ss_s ? 1'b0 : tx_d[FRAME_BITS-1];
    end

    // State registers; SS_n and SCLK synchronizers reset to their idle-high level
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            ss_sync_q   <= '1;
            sclk_sync_q <= '1;
            mosi_sync_q <= '0;
            ss_prev_q   <= 1'b1;
            sclk_prev_q <= 1'b1;
            rx_q        <= '0;
            tx_q        <= '0;
            cnt_q       <= '0;
            miso_q      <= 1'b0;
        end else begin
            ss_sync_q   <= ss_sync_d;
            sclk_sync_q <= sclk_sync_d;
            mosi_sync_q <= mosi_sync_d;
            ss_prev_q   <= ss_prev_d;
            sclk_prev_q <= sclk_prev_d;
            rx_q        <= rx_d;
            tx_q        <= tx_d;
            cnt_q       <= cnt_d;
            miso_q      <= miso_d;
        end
    end

    assign miso     = miso_q;
    assign rx_word  = rx_q;
    assign edge_cnt = cnt_q;

endmodule

// File: rtl/analog_model.sv
// SPI A/D converter model: channel decode and one-frame-pipelined capture.
// Optional build macro: ANALOG_NOISE_EN perturbs result[1:0] with an LFSR.
module analog_model
    import analog_model_pkg::*;
#(
    parameter int unsigned SYNC_STAGES = 2
) (
    input  logic                 clk,
    input  logic                 RST,
    input  logic                 SS_n,
    input  logic                 SCLK,
    input  logic                 MOSI,
    output logic                 MISO,
    input  logic [DATA_BITS-1:0] BATT,
    input  logic [DATA_BITS-1:0] CURR,
    input  logic [DATA_BITS-1:0] BRAKE,
    input  logic [DATA_BITS-1:0] TORQUE
);

    logic [FRAME_BITS-1:0] rx_word;
    logic [FRAME_BITS-1:0] load_word;
    logic [CNT_W-1:0]      edge_cnt;
    logic                  ss_rise_c;
    logic [CH_W-1:0]       channel;
    logic [DATA_BITS-1:0]  sel_value;
    logic                  capture;
    logic [DATA_BITS-1:0]  result_q, result_d;
    logic                  unused_rx;

    spi_slave_shift #(
        .SYNC_STAGES (SYNC_STAGES)
    ) u_shift (
        .clk       (clk),
        .rst       (RST),
        .ss_n      (SS_n),
        .sclk      (SCLK),
        .mosi      (MOSI),
        .load_word (load_word),
        .miso      (MISO),
        .rx_word   (rx_word),
        .edge_cnt  (edge_cnt),
        .ss_rise_c (ss_rise_c)
    );

    assign load_word = {{(FRAME_BITS-DATA_BITS){1'b0}}, result_q};
    assign unused_rx = ^{rx_word[FRAME_BITS-1:CH_LSB+CH_W], rx_word[CH_LSB-1:0]};

`ifdef ANALOG_NOISE_EN
    logic [LFSR_W-1:0] lfsr_q, lfsr_d;
`endif

    // Channel decode and capture on the close of a complete 16-edge frame
    always_comb begin
        channel = rx_word[CH_LSB +: CH_W];
        case (channel)
            CH_BATT:   sel_value = BATT;
            CH_CURR:   sel_value = CURR;
            CH_BRAKE:  sel_value = BRAKE;
            CH_TORQUE: sel_value = TORQUE;
            default:   sel_value = '0;
        endcase

        capture  = ss_rise_c && (edge_cnt == CNT_W'(FRAME_BITS));
        result_d = result_q;
`ifdef ANALOG_NOISE_EN
        lfsr_d = lfsr_q;
        if (capture) begin
            result_d = sel_value ^ {{(DATA_BITS-2){1'b0}}, lfsr_q[1:0]};
            lfsr_d   = lfsr_next(lfsr_q);
        end
`else
        if (capture) begin
            result_d = sel_value;
        end
`endif
    end

    // Conversion result (and noise generator) registers
    always_ff @(posedge clk or posedge RST) begin
        if (RST) begin
            result_q <= '0;
`ifdef ANALOG_NOISE_EN
            lfsr_q   <= LFSR_SEED;
`endif
        end else begin
            result_q <= result_d;
`ifdef ANALOG_NOISE_EN
            lfsr_q   <= lfsr_d;
`endif
        end
    end

endmodule

// File: tb/tb_analog_model.sv
// Scoreboard bench for analog_model: SPI master stimulus, MISO monitor.
module tb_analog_model;

    localparam int HALF = 8;
    localparam int GAP  = 8;

    logic        clk = 1'b0;
    logic        RST;
    logic        SS_n;
    logic        SCLK;
    logic        MOSI;
    logic        MISO;
    logic [11:0] BATT, CURR, BRAKE, TORQUE;

    int n_checks = 0;
    int n_fail   = 0;

    logic [15:0] exp_q[$];
    logic [15:0] mon_word = '0;
    int          mon_n    = 0;

    analog_model #(.SYNC_STAGES(2)) dut (
        .clk    (clk),
        .RST    (RST),
        .SS_n   (SS_n),
        .SCLK   (SCLK),
        .MOSI   (MOSI),
        .MISO   (MISO),
        .BATT   (BATT),
        .CURR   (CURR),
        .BRAKE  (BRAKE),
        .TORQUE (TORQUE)
    );

    always #5 clk = ~clk;

    task automatic check(input string name, input logic [15:0] got, input logic [15:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h", name, got, exp);
        end
    endtask

    // Monitor: collect MISO at each SCLK rise, compare complete frames
    always @(negedge SS_n) begin
        mon_n    = 0;
        mon_word = '0;
    end

    always @(posedge SCLK) begin
        if (SS_n === 1'b0) begin
            mon_word = {mon_word[14:0], MISO};
            mon_n++;
        end
    end

    always @(posedge SS_n) begin
        if (mon_n == 16) begin
            if (exp_q.size() == 0) begin
                n_checks++;
                n_fail++;
                $display("FAIL frame: got %h expected nothing queued", mon_word);
            end else begin
                check("frame", mon_word, exp_q.pop_front());
            end
        end
        mon_n = 0;
    end

    task automatic spi_bit(input logic b);
        SCLK = 1'b0;
        MOSI = b;
        repeat (HALF) @(negedge clk);
        SCLK = 1'b1;
        repeat (HALF) @(negedge clk);
    endtask

    // Full frame: expected readout pushed before the frame is issued
    task automatic frame(input logic [15:0] cmd, input int nbits, input logic [15:0] exp, input bit scored);
        if (scored) exp_q.push_back(exp);
        @(negedge clk);
        SS_n = 1'b0;
        repeat (HALF) @(negedge clk);
        for (int i = 0; i < nbits; i++) begin
            spi_bit(i < 16 ? cmd[15-i] : 1'b0);
        end
        SS_n = 1'b1;
        MOSI = 1'b0;
        repeat (GAP) @(negedge clk);
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        RST    = 1'b1;
        SS_n   = 1'b1;
        SCLK   = 1'b1;
        MOSI   = 1'b0;
        BATT   = 12'hFF0;
        CURR   = 12'h000;
        BRAKE  = 12'h000;
        TORQUE = 12'h000;
        repeat (4) @(negedge clk);
        check("reset_miso", {15'd0, MISO}, 16'h0000);
        RST = 1'b0;
        repeat (4) @(negedge clk);

        frame(16'h0000, 16, 16'h0000, 1'b1);  // first after reset
        frame(16'h0000, 16, 16'h0FF0, 1'b1);  // BATT FF0

        // Frame aborted by reset while MISO is driving a 1
        @(negedge clk);
        SS_n = 1'b0;
        repeat (HALF) @(negedge clk);
        for (int i = 0; i < 5; i++) spi_bit(1'b0);
        RST = 1'b1;
        repeat (2) @(negedge clk);
        check("miso_in_reset", {15'd0, MISO}, 16'h0000);
        SS_n = 1'b1;
        repeat (4) @(negedge clk);
        RST = 1'b0;
        repeat (GAP) @(negedge clk);

        BATT = 12'h000;
        frame(16'h0000, 16, 16'h0000, 1'b1);  // result cleared by reset
        frame(16'h0000, 16, 16'h0000, 1'b1);
        frame(16'h0000, 16, 16'h0000, 1'b1);

        TORQUE = 12'h500;
        frame(16'h2000, 16, 16'h0000, 1'b1);
        TORQUE = 12'h7FF;
        frame(16'h2000, 16, 16'h0500, 1'b1);
        frame(16'h1800, 16, 16'h07FF, 1'b1);  // BRAKE 000 captured
        BRAKE = 12'hFF0;
        frame(16'h1800, 16, 16'h0000, 1'b1);  // BRAKE FF0 captured
        frame(16'h1000, 16, 16'h0FF0, 1'b1);  // channel 2 captured
        CURR = 12'h123;
        frame(16'h0800, 16, 16'h0000, 1'b1);  // CURR 123 captured

        // CURR changes mid readout; shifted word must stay 0123
        fork
            frame(16'h0800, 16, 16'h0123, 1'b1);
            begin
                repeat (60) @(negedge clk);
                CURR = 12'h456;
            end
        join

        frame(16'h2000, 8, 16'h0000, 1'b0);   // aborted 8-edge frame
        frame(16'hE7FF, 16, 16'h0456, 1'b1);  // junk bits around channel 4
        frame(16'h0000, 48, 16'h0000, 1'b0);  // counter saturates, frame discarded
        frame(16'h3800, 16, 16'h07FF, 1'b1);  // channel 7 captured
        frame(16'h0000, 16, 16'h0000, 1'b1);

        repeat (10) @(negedge clk);
        check("queue_drain", 16'(exp_q.size()), 16'h0000);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule

// File: doc/analog_model.md
ANALOG_MODEL -- requirements
Module: analog_model

Interface
- REQ-001 SHALL have parameter SYNC_STAGES, default 2, giving the number of clk-domain synchronizer flops on SS_n, SCLK and MOSI (legal range 2..3).
- REQ-002 SHALL have clk  input  1  system clock; all state is clocked on its rising edge.
- REQ-003 SHALL have RST  input  1  reset, asynchronous and active-high.
- REQ-004 SHALL have SS_n  input  1  SPI slave select, active low, framing one 16-bit transaction.
- REQ-005 SHALL have SCLK  input  1  SPI clock from the master; idles high; frequency at most clk/8.
- REQ-006 SHALL have MOSI  input  1  SPI command data, MSB first.
- REQ-007 SHALL have MISO  output  1  SPI conversion data, MSB first.
- REQ-008 SHALL have BATT, CURR, BRAKE, TORQUE  input  12 each  unsigned analog levels for channels 0, 1, 3 and 4.

Function
- REQ-009 SHALL synchronize SS_n, SCLK and MOSI into clk, and SHALL detect SCLK rise, SCLK fall, SS_n fall and SS_n rise from the synchronized copies.
- REQ-010 SHALL, on each SCLK rise while SS_n is low, shift the synchronized MOSI into a 16-bit rx register at the LSB and increment a 5-bit edge counter.
- REQ-011 SHALL, on SS_n fall, load a 16-bit tx register with {4'h0, result[11:0]}, clear the edge counter and drive MISO = tx[15] in the next cycle.
- REQ-012 SHALL, on each SCLK fall while SS_n is low, shift tx left by one, filling with 0, so MISO presents the next bit before the following SCLK rise.
- REQ-013 SHALL drive MISO to 0 while SS_n is high.
- REQ-014 SHALL, on SS_n rise when the edge counter equals exactly 16, decode channel = rx[13:11] and capture the selected input into result in the same cycle.
- REQ-015 SHALL map channel 0 to BATT, 1 to CURR, 3 to BRAKE and 4 to TORQUE; channels 2, 5, 6 and 7 SHALL yield 12'h000.
- REQ-016 SHALL discard any frame with an edge count other than 16: result is left unchanged.
- REQ-017 SHALL return, during each frame, the conversion requested by the previous valid frame (one-frame pipeline); back-to-back frames SHALL work with a minimum SS_n-high time of 4 clk.
- REQ-018 SHALL NOT let input changes after capture, including mid-frame changes, alter the word being shifted out.
- REQ-019 SHALL ignore rx bits other than [13:11].
- REQ-020 SHALL keep the edge counter saturating at 31.

Reset
- REQ-021 SHALL, while RST is high, clear rx, tx, result, the edge counter and the synchronizers (SS_n and SCLK to 1), and hold MISO at 0.
- REQ-022 SHALL abort any frame in progress on reset, so the first valid frame after reset returns 16'h0000.

Configuration
- REQ-023 SHALL, when macro ANALOG_NOISE_EN is defined, XOR result[1:0] at capture with bits [1:0] of a 16-bit Fibonacci LFSR (taps 16,14,13,11; seed 16'hACE1 on reset) that advances once per valid frame.
- REQ-024 SHALL, without ANALOG_NOISE_EN, capture the exact input value and contain no LFSR logic.

Structure
- REQ-025 SHALL take the channel-number constants, FRAME_BITS = 16, DATA_BITS = 12 and the LFSR seed from package analog_model_pkg.
- REQ-026 SHALL place synchronization, edge detection and the rx/tx shift registers in sub-module spi_slave_shift; channel decode, capture and noise SHALL stay in analog_model.

Verification
- REQ-027 SHALL verify: RST high mid-frame -> MISO 0; the next two frames (cmd 16'h0000 twice) return 16'h0000, then 16'h0000 again with BATT = 0.
- REQ-028 SHALL verify: BATT = 12'hFF0, cmd 16'h0000 then any frame -> second frame shifts 16'h0FF0.
- REQ-029 SHALL verify: TORQUE = 12'h500, cmd 16'h2000 -> next frame 16'h0500; then TORQUE = 12'h7FF and a repeated cmd -> 16'h07FF.
- REQ-030 SHALL verify: BRAKE = 12'h000, cmd 16'h1800 -> 16'h0000; then BRAKE = 12'hFF0 -> 16'h0FF0; cmd 16'h1000 (channel 2) -> 16'h0000.
- REQ-031 SHALL verify: CURR changed from 12'h123 to 12'h456 during the readout frame -> the frame still shifts 16'h0123.
- REQ-032 SHALL verify: an aborted 8-edge frame -> result unchanged; the following frame returns the prior conversion.
